// File: rtl/matrix_isa_pkg.sv
// matrix_isa_pkg: shared ISA constants and sequencer state encoding for the matrix unit
//   Opcodes   : OP_ADD..OP_MULT (0x00-0x04) are executable, OP_STOP ends a program.
//   Fields    : 32-bit word = opcode[31:24] | dest[23:16] | src1[15:8] | src2[7:0].
//   state_t   : fetch sequencer FSM states.
package matrix_isa_pkg;
    localparam int ISA_FIELD_W = 8;
    localparam int ISA_OPC_LSB = 24;
    localparam int ISA_DST_LSB = 16;
    localparam int ISA_SR1_LSB = 8;
    localparam int ISA_SR2_LSB = 0;
    localparam logic [7:0] OP_ADD       = 8'h00;
    localparam logic [7:0] OP_SUB       = 8'h01;
    localparam logic [7:0] OP_TRANSPOSE = 8'h02;
    localparam logic [7:0] OP_SCALE     = 8'h03;
    localparam logic [7:0] OP_MULT      = 8'h04;
    localparam logic [7:0] OP_STOP      = 8'hFF;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_ISSUE,
        S_DONE
    } state_t;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: splits an instruction word into its four fields and classifies the opcode
//   word     in  INSTR_W  raw instruction word
//   opcode   out FIELD_W  word[31:24]
//   dest     out FIELD_W  word[23:16]
//   src1     out FIELD_W  word[15:8]
//   src2     out FIELD_W  word[7:0]
//   isStop   out 1        opcode equals STOP_OP
//   isLegal  out 1        opcode is an executable op or the stop op
module instr_field_decode
    import matrix_isa_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int FIELD_W = ISA_FIELD_W,
    parameter logic [FIELD_W-1:0] STOP_OP = OP_STOP
) (
    input  logic [INSTR_W-1:0] word,
    output logic [FIELD_W-1:0] opcode,
    output logic [FIELD_W-1:0] dest,
    output logic [FIELD_W-1:0] src1,
    output logic [FIELD_W-1:0] src2,
    output logic               isStop,
    output logic               isLegal
);
    assign {opcode, dest, src1, src2} = word;
    assign isStop  = opcode == STOP_OP;
    // Executable opcodes are the contiguous range starting at OP_ADD (0x00).
    assign isLegal = opcode <= FIELD_W'(OP_MULT) || isStop;
endmodule

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches instructions from memory and issues decoded fields to the matrix unit
//   clk           in  1        clock, rising edge
//   nReset        in  1        asynchronous active-low reset
//   start         in  1        begin program at address 0 (honoured only in IDLE/DONE)
//   instrNumber   out ADDR_W   instruction address to memory
//   nIMemEnable   out 1        active-low memory read enable, low only in FETCH
//   instrMemLine  in  INSTR_W  word returned by memory
//   opcode/dest/src1/src2 out FIELD_W  fields of the issued instruction
//   issueValid    out 1        fields valid
//   issueReady    in  1        execution unit accepts the fields
//   busy          out 1        program in progress
//   done          out 1        program ended, held until next start
//   error         out 1        program ended abnormally, held until next start
// Build option: define ILLEGAL_OP_CHECK_EN to end the program with an error on
// any opcode outside OP_ADD..OP_MULT and STOP_OP instead of issuing it.
module instr_fetch_sequencer
    import matrix_isa_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int INSTR_W = 32,
    parameter int FIELD_W = ISA_FIELD_W,
    parameter logic [FIELD_W-1:0] STOP_OP = OP_STOP
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               start,
    output logic [ADDR_W-1:0]  instrNumber,
    output logic               nIMemEnable,
    input  logic [INSTR_W-1:0] instrMemLine,
    output logic [FIELD_W-1:0] opcode,
    output logic [FIELD_W-1:0] dest,
    output logic [FIELD_W-1:0] src1,
    output logic [FIELD_W-1:0] src2,
    output logic               issueValid,
    input  logic               issueReady,
    output logic               busy,
    output logic               done,
    output logic               error
);
`ifdef ILLEGAL_OP_CHECK_EN
    localparam bit ILLEGAL_CHK = 1'b1;
`else
    localparam bit ILLEGAL_CHK = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [4*FIELD_W-1:0]     fld_q, fld_d;
    logic                     valid_d, busy_d, done_d, err_d;
    logic [FIELD_W-1:0]       dec_op, dec_dst, dec_src1, dec_src2;
    logic                     is_stop, is_legal, bad_op;

    instr_field_decode #(
        .INSTR_W(INSTR_W),
        .FIELD_W(FIELD_W),
        .STOP_OP(STOP_OP)
    ) u_decode (
        .word   (instrMemLine),
        .opcode (dec_op),
        .dest   (dec_dst),
        .src1   (dec_src1),
        .src2   (dec_src2),
        .isStop (is_stop),
        .isLegal(is_legal)
    );

    assign bad_op      = ILLEGAL_CHK && !is_legal;
    // pc only changes on the edge that enters FETCH, so it doubles as the held address.
    assign instrNumber = pc_q;
    assign nIMemEnable = state_q != S_FETCH;
    assign {opcode, dest, src1, src2} = fld_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fld_d   = fld_q;
        valid_d = issueValid;
        busy_d  = busy;
        done_d  = done;
        err_d   = error;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (is_stop || bad_op) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = !is_stop;
                    state_d = S_DONE;
                end else begin
                    fld_d   = {dec_op, dec_dst, dec_src1, dec_src2};
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issueReady) begin
                    valid_d = 1'b0;
                    // Running off the end of the address space without a stop is an error; no wrap.
                    if (pc_q == PC_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            fld_q      <= '0;
            issueValid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fld_q      <= fld_d;
            issueValid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed and randomized programs checked against a program-walk model
module tb_instr_fetch_sequencer;
`ifdef ILLEGAL_OP_CHECK_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic        issueReady = 1'b0;
    logic [2:0]  instrNumber;
    logic        nIMemEnable;
    logic [31:0] instrMemLine = '0;
    logic [7:0]  opcode, dest, src1, src2;
    logic        issueValid, busy, done, error;
    logic [31:0] mem [8];
    logic [31:0] exp_q [$];
    int          exp_nf;
    bit          exp_err;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (!nIMemEnable) instrMemLine <= mem[instrNumber];

    instr_fetch_sequencer dut (
        .clk(clk), .nReset(nReset), .start(start),
        .instrNumber(instrNumber), .nIMemEnable(nIMemEnable), .instrMemLine(instrMemLine),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .issueValid(issueValid), .issueReady(issueReady),
        .busy(busy), .done(done), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset();
        chk("rst_nmem", 32'(nIMemEnable), 1);
        chk("rst_addr", 32'(instrNumber), 0);
        chk("rst_fields", {opcode, dest, src1, src2}, 0);
        chk("rst_flags", 32'({issueValid, busy, done, error}), 0);
    endtask

    // Walk memory as a program: stop word ends cleanly, illegal op (when checked) or
    // running past the last address ends with an error.
    task automatic model();
        logic [7:0] op;
        exp_q = {};
        exp_err = 1'b0;
        exp_nf = 0;
        for (int a = 0; a < 8; a++) begin
            op = mem[a][31:24];
            exp_nf = a + 1;
            if (op == 8'hFF) break;
            if (ILL && op > 8'h04) begin
                exp_err = 1'b1;
                break;
            end
            exp_q.push_back(mem[a]);
            if (a == 7) exp_err = 1'b1;
        end
    endtask

    task automatic load_demo();
        mem[0] = 32'h00020001; mem[1] = 32'h01030200; mem[2] = 32'h020402ff;
        mem[3] = 32'h030b0408; mem[4] = 32'h04050b04; mem[5] = 32'hffffffff;
        mem[6] = 32'h01010101; mem[7] = 32'h02020202;
    endtask

    task automatic load_random(input bit allow_end);
        logic [7:0] op;
        int r;
        for (int a = 0; a < 8; a++) begin
            r = int'($urandom_range(0, 9));
            op = (r == 7 && allow_end) ? 8'hFF :
                 (r == 8 && allow_end) ? 8'($urandom_range(5, 254)) : 8'($urandom_range(0, 4));
            mem[a] = {op, 24'($urandom)};
        end
    endtask

    task automatic run(input bit rnd, input int stall_idx, input int stall_len, input int restart_at);
        logic [31:0] held = '0;
        int got = 0, nf_got = 0, last = 0, cyc = 0, scnt = 0;
        bit pv = 1'b0, fin = 1'b0;
        model();
        @(negedge clk);
        start = 1'b1;
        issueReady = 1'b1;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!nIMemEnable) begin
                chk("fetch_addr", 32'(instrNumber), nf_got);
                chk("fetch_while_valid", 32'(issueValid), 0);
                nf_got++;
            end
            if (issueValid) begin
                if (!pv) begin
                    chk("issue_gap", cyc - last, 3);
                    if (got < exp_q.size()) chk("issue_fields", {opcode, dest, src1, src2}, exp_q[got]);
                    else chk("issue_extra", got, exp_q.size());
                end else chk("issue_hold", {opcode, dest, src1, src2}, held);
                held = {opcode, dest, src1, src2};
                chk("busy_in_issue", 32'(busy), 1);
                issueReady = rnd ? 1'($urandom_range(0, 1)) : !(got == stall_idx && scnt < stall_len);
                if (!issueReady && !rnd) scnt++;
                if (issueReady) begin
                    got++;
                    last = cyc;
                end
            end
            pv = issueValid;
            fin = done;
            start = !fin && cyc == restart_at;
        end
        start = 1'b0;
        chk("timeout", 32'(fin), 1);
        chk("n_issues", got, exp_q.size());
        chk("n_fetches", nf_got, exp_nf);
        chk("done", 32'(done), 1);
        chk("error", 32'(error), 32'(exp_err));
        chk("busy_end", 32'(busy), 0);
        chk("valid_end", 32'(issueValid), 0);
        chk("addr_hold", 32'(instrNumber), exp_nf - 1);
        repeat (3) @(negedge clk);
        chk("idle_nmem", 32'(nIMemEnable), 1);
        chk("done_held", 32'({done, error}), 32'({1'b1, exp_err}));
    endtask

    initial begin
        for (int a = 0; a < 8; a++) mem[a] = '0;
        #12;
        chk_reset();
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        chk_reset();

        load_demo();
        run(1'b0, -1, 0, 0);
        run(1'b0, 2, 5, 0);

        load_random(1'b0);
        run(1'b0, -1, 0, 0);
        load_random(1'b0);
        run(1'b1, -1, 0, 0);

        load_demo();
        @(negedge clk);
        start = 1'b1;
        issueReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        issueReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", 32'(issueValid), 1);
        chk("pre_rst_instr1", {opcode, dest, src1, src2}, 32'h01030200);
        chk("pre_rst_addr", 32'(instrNumber), 1);
        #2 nReset = 1'b0;
        #1 chk_reset();
        @(negedge clk);
        nReset = 1'b1;
        run(1'b0, -1, 0, 0);

        for (int a = 0; a < 8; a++) mem[a] = 32'h01000000;
        mem[0] = 32'h07000000;
        mem[1] = 32'hffffffff;
        run(1'b0, -1, 0, 0);

        load_demo();
        run(1'b0, -1, 0, 4);

        repeat (6) begin
            load_random(1'b1);
            run(1'b1, -1, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
